// File: rtl/terminal_write_arbiter.sv
// terminal_write_arbiter
//   Shares the single write port of the terminal text buffer between the
//   debugger overlay and the CPU memory-mapped console (round-robin, req/ack),
//   and sequences a full-screen clear on request.
//
// Ports:
//   clock          block clock, all state on rising edge
//   reset          asynchronous active-low reset
//   dbg_req/addr/data, dbg_ack   debugger write request, one-cycle accept pulse
//   cpu_req/addr/data, cpu_ack   CPU console write request, one-cycle accept pulse
//   clear_req      starts a screen clear when sampled in IDLE
//   busy           high while a clear is in progress
//   terminal_addr/write/data     text buffer write port (registered)
module terminal_write_arbiter #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [7:0]            dbg_data,
    output logic                  dbg_ack,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_data,
    output logic                  cpu_ack,
    input  logic                  clear_req,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] terminal_addr,
    output logic                  terminal_write,
    output logic [7:0]            terminal_data
);

    localparam int unsigned           CELLS     = COLS * ROWS;
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CELLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } state_t;

    typedef enum logic {
        GRANT_DBG,
        GRANT_CPU
    } grant_t;

    state_t                state;
    grant_t                last_grant;
    logic [ADDR_WIDTH-1:0] counter;

    logic                  grant_dbg;
    logic                  grant_cpu;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_data;
    logic                  sel_in_range;

    // On a tie the debugger wins only if the CPU had the last grant.
    always_comb begin
        grant_dbg    = dbg_req && (!cpu_req || (last_grant == GRANT_CPU));
        grant_cpu    = cpu_req && !grant_dbg;
        sel_addr     = grant_dbg ? dbg_addr : cpu_addr;
        sel_data     = grant_dbg ? dbg_data : cpu_data;
        sel_in_range = (sel_addr <= LAST_CELL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= GRANT_CPU;
            counter        <= '0;
            dbg_ack        <= 1'b0;
            cpu_ack        <= 1'b0;
            busy           <= 1'b0;
            terminal_addr  <= '0;
            terminal_write <= 1'b0;
            terminal_data  <= '0;
        end else begin
            dbg_ack        <= 1'b0;
            cpu_ack        <= 1'b0;
            terminal_write <= 1'b0;

            case (state)
                IDLE: begin
                    if (clear_req) begin
                        // The first clear write is issued together with busy.
                        state          <= CLEAR;
                        counter        <= '0;
                        busy           <= 1'b1;
                        terminal_addr  <= '0;
                        terminal_data  <= CLEAR_CHAR;
                        terminal_write <= 1'b1;
                    end else if (grant_dbg || grant_cpu) begin
                        state          <= WRITE;
                        terminal_addr  <= sel_addr;
                        terminal_data  <= sel_data;
                        // Off-screen writes are acked but dropped.
                        terminal_write <= sel_in_range;
                        dbg_ack        <= grant_dbg;
                        cpu_ack        <= grant_cpu;
                        last_grant     <= grant_dbg ? GRANT_DBG : GRANT_CPU;
                    end
                end

                WRITE: begin
                    state <= IDLE;
                end

                CLEAR: begin
                    // counter holds the address being written this cycle;
                    // checking it before incrementing keeps it from wrapping.
                    if (counter == LAST_CELL) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter        <= counter + 1'b1;
                        terminal_addr  <= counter + 1'b1;
                        terminal_data  <= CLEAR_CHAR;
                        terminal_write <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_terminal_write_arbiter.sv
// tb_terminal_write_arbiter
//   Directed table of single-cycle vectors plus hand-written sequences for
//   round-robin streaming, screen clear, reset mid-clear and clear/write
//   collision. Inputs are driven and outputs sampled on the falling edge.
module tb_terminal_write_arbiter;

    logic        clock;
    logic        reset;
    logic        dbg_req;
    logic [11:0] dbg_addr;
    logic [7:0]  dbg_data;
    logic        dbg_ack;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ack;
    logic        clear_req;
    logic        busy;
    logic [11:0] terminal_addr;
    logic        terminal_write;
    logic [7:0]  terminal_data;

    int vectors;
    int miscompares;

    terminal_write_arbiter #(
        .COLS(80),
        .ROWS(30),
        .ADDR_WIDTH(12),
        .CLEAR_CHAR(8'h20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dbg_req(dbg_req),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .dbg_ack(dbg_ack),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .cpu_data(cpu_data),
        .cpu_ack(cpu_ack),
        .clear_req(clear_req),
        .busy(busy),
        .terminal_addr(terminal_addr),
        .terminal_write(terminal_write),
        .terminal_data(terminal_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {dbg_ack, cpu_ack, busy, terminal_write, terminal_addr, terminal_data}
    logic [23:0] obs;
    assign obs = {dbg_ack, cpu_ack, busy, terminal_write, terminal_addr, terminal_data};

    function automatic logic [23:0] ex(input logic da, input logic ca, input logic b,
                                       input logic w, input logic [11:0] a,
                                       input logic [7:0] d);
        return {da, ca, b, w, a, d};
    endfunction

    typedef struct {
        logic        dr;
        logic [11:0] da;
        logic [7:0]  dd;
        logic        cr;
        logic [11:0] ca;
        logic [7:0]  cd;
        logic        clr;
        logic [23:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic dr, input logic [11:0] da, input logic [7:0] dd,
                                input logic cr, input logic [11:0] ca, input logic [7:0] cd,
                                input logic clr, input logic [23:0] exp);
        vec_t v;
        v.dr = dr; v.da = da; v.dd = dd;
        v.cr = cr; v.ca = ca; v.cd = cd;
        v.clr = clr; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    vec_t        tbl[16];
    logic [11:0] last_a;
    logic [7:0]  last_d;
    logic        dbg_turn;
    int          errs;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        dbg_req     = 1'b0; dbg_addr = '0; dbg_data = '0;
        cpu_req     = 1'b0; cpu_addr = '0; cpu_data = '0;
        clear_req   = 1'b0;

        // Reset held: toggling inputs must not move any output.
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            dbg_req   = $urandom_range(0, 1);
            cpu_req   = $urandom_range(0, 1);
            clear_req = $urandom_range(0, 1);
            dbg_addr  = 12'($urandom);
            cpu_addr  = 12'($urandom);
            dbg_data  = 8'($urandom);
            cpu_data  = 8'($urandom);
            cycle();
            check("reset_hold", obs, '0);
        end
        dbg_req = 1'b0; cpu_req = 1'b0; clear_req = 1'b0;
        reset   = 1'b1;

        // Each vector: inputs sampled at one edge, expected outputs after it.
        tbl[0]  = mk(0, 12'h000, 8'h00, 0, 12'h000, 8'h00, 0, ex(0,0,0,0,12'h000,8'h00));
        tbl[1]  = mk(1, 12'h005, 8'h41, 0, 12'h000, 8'h00, 0, ex(1,0,0,1,12'h005,8'h41));
        tbl[2]  = mk(1, 12'h005, 8'h41, 0, 12'h000, 8'h00, 0, ex(0,0,0,0,12'h005,8'h41));
        tbl[3]  = mk(0, 12'h005, 8'h41, 0, 12'h000, 8'h00, 0, ex(0,0,0,0,12'h005,8'h41));
        tbl[4]  = mk(1, 12'h00A, 8'h42, 1, 12'h014, 8'h61, 0, ex(0,1,0,1,12'h014,8'h61));
        tbl[5]  = mk(1, 12'h00A, 8'h42, 1, 12'h014, 8'h61, 0, ex(0,0,0,0,12'h014,8'h61));
        tbl[6]  = mk(1, 12'h00A, 8'h42, 1, 12'h014, 8'h61, 0, ex(1,0,0,1,12'h00A,8'h42));
        tbl[7]  = mk(1, 12'h00A, 8'h42, 1, 12'h014, 8'h61, 0, ex(0,0,0,0,12'h00A,8'h42));
        tbl[8]  = mk(0, 12'h00A, 8'h42, 1, 12'h960, 8'h62, 0, ex(0,1,0,0,12'h960,8'h62));
        tbl[9]  = mk(0, 12'h00A, 8'h42, 0, 12'h960, 8'h62, 0, ex(0,0,0,0,12'h960,8'h62));
        tbl[10] = mk(1, 12'h95F, 8'h43, 0, 12'h960, 8'h62, 0, ex(1,0,0,1,12'h95F,8'h43));
        tbl[11] = mk(0, 12'h95F, 8'h43, 0, 12'h960, 8'h62, 0, ex(0,0,0,0,12'h95F,8'h43));
        tbl[12] = mk(0, 12'h95F, 8'h43, 1, 12'hFFF, 8'h63, 0, ex(0,1,0,0,12'hFFF,8'h63));
        tbl[13] = mk(0, 12'h95F, 8'h43, 0, 12'hFFF, 8'h63, 0, ex(0,0,0,0,12'hFFF,8'h63));
        tbl[14] = mk(1, 12'h000, 8'h44, 1, 12'h001, 8'h64, 0, ex(1,0,0,1,12'h000,8'h44));
        tbl[15] = mk(0, 12'h000, 8'h44, 0, 12'h001, 8'h64, 0, ex(0,0,0,0,12'h000,8'h44));

        for (int i = 0; i < 16; i++) begin
            dbg_req   = tbl[i].dr; dbg_addr = tbl[i].da; dbg_data = tbl[i].dd;
            cpu_req   = tbl[i].cr; cpu_addr = tbl[i].ca; cpu_data = tbl[i].cd;
            clear_req = tbl[i].clr;
            cycle();
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // Round-robin stream: last grant was DBG, so CPU goes first.
        dbg_req = 1'b1; dbg_addr = 12'd100; dbg_data = 8'h80;
        cpu_req = 1'b1; cpu_addr = 12'd200; cpu_data = 8'hC0;
        last_a  = 12'h000; last_d = 8'h44;
        dbg_turn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (i % 2 == 0) begin
                if (dbg_turn) begin
                    check($sformatf("rr%0d_dbg", i), obs, ex(1,0,0,1,dbg_addr,dbg_data));
                    last_a = dbg_addr; last_d = dbg_data;
                    dbg_data = dbg_data + 8'd1;
                end else begin
                    check($sformatf("rr%0d_cpu", i), obs, ex(0,1,0,1,cpu_addr,cpu_data));
                    last_a = cpu_addr; last_d = cpu_data;
                    cpu_data = cpu_data + 8'd1;
                end
                dbg_turn = ~dbg_turn;
            end else begin
                check($sformatf("rr%0d_gap", i), obs, ex(0,0,0,0,last_a,last_d));
            end
        end
        dbg_req = 1'b0; cpu_req = 1'b0;

        // Screen clear with a CPU request held throughout.
        cpu_req = 1'b1; cpu_addr = 12'd7; cpu_data = 8'h65;
        clear_req = 1'b1;
        errs = 0;
        for (int k = 0; k < 2400; k++) begin
            cycle();
            clear_req = 1'b0;
            if (obs !== ex(0,0,1,1,12'(k),8'h20)) begin
                if (errs == 0)
                    $display("FAIL clear_cell%0d: got %h expected %h", k, obs,
                             ex(0,0,1,1,12'(k),8'h20));
                errs++;
            end
        end
        check("clear_bad_cells", 24'(errs), 24'd0);
        cycle();
        check("clear_done", obs, ex(0,0,0,0,12'h95F,8'h20));
        cycle();
        check("clear_cpu_ack", obs, ex(0,1,0,1,12'd7,8'h65));
        cpu_req = 1'b0;
        cycle();
        check("clear_cpu_gap", obs, ex(0,0,0,0,12'd7,8'h65));

        // Reset in the middle of a clear.
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        check("mid_clear_start", obs, ex(0,0,1,1,12'd0,8'h20));
        for (int k = 1; k <= 1000; k++) cycle();
        check("mid_clear_1000", obs, ex(0,0,1,1,12'd1000,8'h20));
        reset = 1'b0;
        #1;
        check("mid_clear_reset", obs, '0);
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("after_reset%0d", i), obs, '0);
        end

        // Clear request raised during a WRITE wins over the pending CPU request.
        dbg_req = 1'b1; dbg_addr = 12'd30; dbg_data = 8'h46;
        cpu_req = 1'b1; cpu_addr = 12'd40; cpu_data = 8'h66;
        cycle();
        check("coll_dbg_ack", obs, ex(1,0,0,1,12'd30,8'h46));
        dbg_req = 1'b0;
        clear_req = 1'b1;
        cycle();
        check("coll_write_end", obs, ex(0,0,0,0,12'd30,8'h46));
        cycle();
        check("coll_clear0", obs, ex(0,0,1,1,12'd0,8'h20));
        clear_req = 1'b0;
        cycle();
        check("coll_clear1", obs, ex(0,0,1,1,12'd1,8'h20));
        cpu_req = 1'b0;
        reset = 1'b0;
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/terminal_write_arbiter.md
Name: terminal_write_arbiter

Overview:
- Shares the single write port of the terminal text buffer (12-bit address, 8-bit character) between two requesters: the debugger overlay and a CPU memory-mapped console.
- Arbitrates between them round-robin using a req/ack handshake.
- Also sequences a full-screen clear on request.
- Sits between the requesters and the terminal block's text_addr/text_write/text_in inputs, in the 25 MHz debugger clock domain.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows on screen; visible cells = COLS*ROWS = 2400
- ADDR_WIDTH, 12, text buffer address width
- CLEAR_CHAR, 8'h20, character written during a clear

Ports:
- clock  in  1  block clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- dbg_req  in  1  debugger write request, held until dbg_ack
- dbg_addr  in  ADDR_WIDTH  debugger cell address
- dbg_data  in  8  debugger character
- dbg_ack  out  1  one-cycle pulse: debugger write accepted
- cpu_req  in  1  CPU console write request, held until cpu_ack
- cpu_addr  in  ADDR_WIDTH  CPU cell address
- cpu_data  in  8  CPU character
- cpu_ack  out  1  one-cycle pulse: CPU write accepted
- clear_req  in  1  level or pulse; starts a screen clear when sampled in IDLE
- busy  out  1  high while a clear is in progress
- terminal_addr  out  ADDR_WIDTH  text buffer write address
- terminal_write  out  1  text buffer write enable, one cycle per write
- terminal_data  out  8  text buffer write data

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; all outputs 0; clear counter 0.
  - last_grant=CPU, so the debugger wins the first tie.
  - Reset asserted mid-clear or mid-write aborts it; nothing resumes after release.
- All outputs are registered.
- States: IDLE, WRITE, CLEAR.
- IDLE, priority order evaluated on each edge:
  - 1. clear_req=1 -> CLEAR, counter=0, busy=1 next cycle.
  - 2. Both requests high -> grant the requester not equal to last_grant.
  - 3. Otherwise grant whichever request is high.
  - On grant:
    - Latch the granted addr/data into terminal_addr/terminal_data.
    - Set terminal_write=1 and the granted ack=1 for the next cycle; go to WRITE; update last_grant.
  - No request -> terminal_write=0, acks=0.
- WRITE (exactly one cycle):
  - terminal_write and the ack are high during this cycle.
  - Requests are not sampled here; return to IDLE.
  - A requester seeing ack may drop req or present new addr/data with req still high. The next sample is in IDLE, so no duplicate write is possible.
  - Sustained throughput: one write per 2 cycles. Two continuous requesters alternate DBG, CPU, DBG, …
- Out-of-range address (addr >= COLS*ROWS):
  - Request is acked normally; terminal_write stays 0 in the WRITE cycle (write dropped).
  - last_grant is still updated.
- CLEAR:
  - Each cycle: terminal_write=1, terminal_addr=counter, terminal_data=CLEAR_CHAR; counter increments.
  - After writing address COLS*ROWS-1: busy=0 and state=IDLE on the next edge, with terminal_write=0 in that cycle.
  - A clear takes exactly COLS*ROWS write cycles (2400 at defaults).
  - clear_req is ignored during CLEAR.
  - Requests stay pending and un-acked during CLEAR.
  - clear_req arriving while in WRITE is honoured at the next IDLE sample if still high; a one-cycle pulse landing in WRITE is lost. Callers hold clear_req until busy rises.
- Counter width is ADDR_WIDTH; the counter never wraps, because the terminal count is checked before incrementing.
- Invariants:
  - At most one ack per cycle.
  - An ack is never high without the matching req having been high at the sampling edge.
  - During CLEAR, terminal_write is the only active strobe.

Test Plan:
- Reset check: hold reset low, toggle all inputs -> all outputs 0. Release, then dbg_req=1, addr=12'h005, data=8'h41 -> two edges later terminal_write=1, addr=005, data=41, dbg_ack=1 for exactly one cycle.
- Tie and round-robin: dbg_req and cpu_req held high continuously, each requester bumping its data on every ack -> grants alternate DBG, CPU, DBG, CPU; terminal_write pulses every 2nd cycle; no duplicated data values.
- Clear sequencing: clear_req pulse in IDLE with cpu_req held high -> busy high for 2400 cycles, addresses 0..2399 written with 8'h20 in order, no cpu_ack during the clear. The CPU write is acked on the first IDLE cycle after busy falls.
- Out-of-range drop: cpu_addr=12'd2400, cpu_req=1 -> cpu_ack pulses, terminal_write stays 0. A following dbg_req gets the next grant.
- Reset mid-clear: assert reset at counter=1000 -> outputs 0 immediately. After release, state is IDLE with busy=0 and no further clear writes.
- Clear vs. write collision: clear_req rises during a WRITE cycle and is held -> the current write completes, then CLEAR starts before any pending request is granted.
